// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter (1 start, 8 data LSB first, no parity,
// 1 or 2 stop bits) fed by a small FIFO. The serial line comes straight off a flop.
module uart_tx #(
    parameter int NCLKS_PER_BIT = 186,
    parameter int STOP_BITS     = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_DI,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_DO,
    output logic       tx_busy
);
    localparam int CW = (NCLKS_PER_BIT > 1) ? $clog2(NCLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] LAST_CLK  = CW'(NCLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE   = 1;
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_live;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          r_do, w_do_nxt;

    logic          w_push, w_pop, w_full, w_empty, w_bit_end;
    logic [7:0]    w_head;

    // ready is held low until the first edge after reset, and whenever full
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign tx_ready = r_live & ~w_full;
    assign w_push   = tx_valid & tx_ready;
    assign w_head   = r_mem[r_rptr];
    assign w_bit_end = (r_clk_cnt == LAST_CLK);

    assign uart_DO = r_do;
    assign tx_busy = (r_state != IDLE) | ~w_empty;

    // FIFO storage: written only on an accepted byte, so later tx_DI changes are ignored
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= tx_DI;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state, bit-time counter, bit index, shift register and line flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_do      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_do      <= w_do_nxt;
        end
    end

    // next-state: r_bit indexes data bits in DATA and counts stop bits in STOP
    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_clk_cnt_nxt = '0;
                    w_bit_nxt     = '0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_nxt     = '0;
                    w_state_nxt   = DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CLK_ONE;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CLK_ONE;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit == LAST_STOP) begin
                        w_bit_nxt = '0;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_head;
                            w_state_nxt = START;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CLK_ONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // output: line value for the upcoming cycle, registered into r_do
    always_comb begin
        case (w_state_nxt)
            START:   w_do_nxt = 1'b0;
            DATA:    w_do_nxt = w_shift_nxt[w_bit_nxt];
            default: w_do_nxt = 1'b1;
        endcase
    end

endmodule
